// File: rtl/regfile_sync_rd.sv
// Multi-port register file: synchronous write, registered (1-cycle) reads with
// same-edge write->read bypass and an optional hardwired-zero top register.
module regfile_sync_rd #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of 2.
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] TOP_ADDR  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;

    // An address is live when it names a real register other than the zero register.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == TOP_ADDR));
    endfunction

    assign wr_ok = wr_en && addr_live(wr_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] rd_value;
        logic [WIDTH-1:0] data_q;
        logic             valid_q;

        assign addr = rd_addr[p*AW +: AW];

        // A write landing on the same edge overrides the stored value.
        always_comb begin
            rd_value = '0;
            if (addr_live(addr)) begin
                if (wr_ok && (wr_addr == addr)) begin
                    rd_value = wr_data;
                end else begin
                    rd_value = regs[addr];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_en[p];
                if (rd_en[p]) begin
                    data_q <= rd_value;
                end
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = data_q;
        assign rd_valid[p]               = valid_q;
    end

endmodule

// File: tb/tb_regfile_sync_rd.sv
// Bench for regfile_sync_rd: three configurations share one stimulus stream and are
// checked every cycle against an array-based model, plus pinned literal cases.
module tb_regfile_sync_rd;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [2:0]  rd_en = '0;
    logic [14:0] rd_addr = '0;

    logic [127:0] a_rd_data;
    logic [1:0]   a_rd_valid;
    logic [95:0]  b_rd_data, c_rd_data;
    logic [2:0]   b_rd_valid, c_rd_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: defaults, b: non-power-of-2 depth without zero reg, c: full depth without zero reg
    regfile_sync_rd dut_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en[1:0]), .rd_addr(rd_addr[9:0]),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid)
    );

    regfile_sync_rd #(.WIDTH(32), .DEPTH(20), .NRD(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data[31:0]), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid)
    );

    regfile_sync_rd #(.WIDTH(32), .DEPTH(32), .NRD(3), .ZERO_REG(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data[31:0]), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(c_rd_data), .rd_valid(c_rd_valid)
    );

    function automatic int depth_of(int i);
        return (i == 1) ? 20 : 32;
    endfunction

    function automatic int nrd_of(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic [63:0] mask_of(int i);
        return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] act_data(int i, int p);
        case (i)
            0:       return a_rd_data[p*64 +: 64];
            1:       return {32'b0, b_rd_data[p*32 +: 32]};
            default: return {32'b0, c_rd_data[p*32 +: 32]};
        endcase
    endfunction

    function automatic logic act_valid(int i, int p);
        case (i)
            0:       return a_rd_valid[p];
            1:       return b_rd_valid[p];
            default: return c_rd_valid[p];
        endcase
    endfunction

    // Reference model: plain storage arrays plus the expected output per port.
    logic [63:0] mregs [3][32];
    logic [63:0] exp_data [3][3];
    logic        exp_valid [3][3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 32; r++) mregs[i][r] = '0;
            for (int p = 0; p < 3; p++) begin
                exp_data[i][p]  = '0;
                exp_valid[i][p] = 1'b0;
            end
        end
    end

    function automatic logic write_takes(int i);
        int a = int'(wr_addr);
        return wr_en && (a < depth_of(i)) && !(i == 0 && a == depth_of(i) - 1);
    endfunction

    function automatic logic [63:0] model_value(int i, int a);
        if (a >= depth_of(i)) return '0;
        if (i == 0 && a == depth_of(i) - 1) return '0;
        if (write_takes(i) && int'(wr_addr) == a) return wr_data & mask_of(i);
        return mregs[i][a];
    endfunction

    always @(negedge reset_n) begin
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 32; r++) mregs[i][r] = '0;
            for (int p = 0; p < 3; p++) begin
                exp_data[i][p]  = '0;
                exp_valid[i][p] = 1'b0;
            end
        end
    end

    // Reads see the pre-edge storage (plus bypass); the write is applied afterwards.
    always @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < nrd_of(i); p++) begin
                    if (rd_en[p]) begin
                        exp_data[i][p]  = model_value(i, int'(rd_addr[p*5 +: 5]));
                        exp_valid[i][p] = 1'b1;
                    end else begin
                        exp_valid[i][p] = 1'b0;
                    end
                end
                if (write_takes(i)) mregs[i][wr_addr] = wr_data & mask_of(i);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < nrd_of(i); p++) begin
                checkOutput($sformatf("inst%0d_p%0d_valid", i, p),
                            {63'b0, act_valid(i, p)}, {63'b0, exp_valid[i][p]});
                checkOutput($sformatf("inst%0d_p%0d_data", i, p), act_data(i, p), exp_data[i][p]);
            end
        end
    end

    task automatic applyStimulus(input logic we, input int wa, input logic [63:0] wd,
                                 input logic [2:0] re, input int ra0, input int ra1, input int ra2);
        @(negedge clk);
        wr_en   = we;
        wr_addr = 5'(wa);
        wr_data = wd;
        rd_en   = re;
        rd_addr = {5'(ra2), 5'(ra1), 5'(ra0)};
    endtask

    initial begin
        #1 reset_n = 1'b0;
        applyStimulus(0, 0, 0, 3'b000, 0, 0, 0);
        reset_n = 1'b1;

        // Reset discards stored data and clears outputs immediately
        applyStimulus(1, 5, 64'h1234, 3'b001, 5, 0, 0);
        @(posedge clk); #1;
        checkOutput("rst_pre_data", act_data(0, 0), 64'h1234);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_async_data", act_data(0, 0), 64'h0);
        checkOutput("rst_async_valid", {63'b0, act_valid(0, 0)}, 64'h0);
        applyStimulus(0, 0, 0, 3'b001, 5, 0, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_post_r5", act_data(0, 0), 64'h0);
        checkOutput("rst_post_valid", {63'b0, act_valid(0, 0)}, 64'h1);

        // Basic write, read, then hold with valid dropping
        applyStimulus(1, 3, 64'hDEADBEEF_00000001, 3'b000, 0, 0, 0);
        applyStimulus(0, 0, 0, 3'b001, 3, 0, 0);
        @(posedge clk); #1;
        checkOutput("basic_data", act_data(0, 0), 64'hDEADBEEF_00000001);
        checkOutput("basic_valid", {63'b0, act_valid(0, 0)}, 64'h1);
        applyStimulus(0, 0, 0, 3'b000, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("hold_data", act_data(0, 0), 64'hDEADBEEF_00000001);
        checkOutput("hold_valid", {63'b0, act_valid(0, 0)}, 64'h0);

        // Same-edge bypass on both ports
        applyStimulus(1, 7, 64'h55, 3'b000, 0, 0, 0);
        applyStimulus(1, 7, 64'hAA, 3'b011, 7, 7, 7);
        @(posedge clk); #1;
        checkOutput("bypass_p0", act_data(0, 0), 64'hAA);
        checkOutput("bypass_p1", act_data(0, 1), 64'hAA);

        // Zero register versus plain top register
        applyStimulus(1, 31, 64'hFFFF, 3'b011, 31, 31, 31);
        @(posedge clk); #1;
        checkOutput("zero_same_edge", act_data(0, 0), 64'h0);
        checkOutput("nozero_same_edge", act_data(2, 0), 64'hFFFF);
        applyStimulus(0, 0, 0, 3'b011, 31, 31, 31);
        @(posedge clk); #1;
        checkOutput("zero_after", act_data(0, 1), 64'h0);
        checkOutput("nozero_after", act_data(2, 1), 64'hFFFF);
        checkOutput("depth20_oor_read", act_data(1, 0), 64'h0);

        // Non-power-of-2 depth boundaries
        applyStimulus(1, 25, 64'h77, 3'b000, 0, 0, 0);
        applyStimulus(1, 20, 64'h88, 3'b000, 0, 0, 0);
        applyStimulus(1, 0, 64'h1111_2222, 3'b000, 0, 0, 0);
        applyStimulus(1, 19, 64'h3333_4444, 3'b000, 0, 0, 0);
        applyStimulus(0, 0, 0, 3'b111, 0, 19, 25);
        @(posedge clk); #1;
        checkOutput("d20_r0", act_data(1, 0), 64'h1111_2222);
        checkOutput("d20_r19", act_data(1, 1), 64'h3333_4444);
        checkOutput("d20_r25", act_data(1, 2), 64'h0);
        applyStimulus(0, 0, 0, 3'b111, 20, 25, 19);
        @(posedge clk); #1;
        checkOutput("d20_r20", act_data(1, 0), 64'h0);
        checkOutput("d20_r19_again", act_data(1, 2), 64'h3333_4444);

        // Random sweep over all addresses, ports often aimed at the write address
        for (int n = 0; n < 1000; n++) begin
            int wa;
            int ra [3];
            wa = int'($urandom_range(0, 31));
            for (int p = 0; p < 3; p++) begin
                ra[p] = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
            end
            applyStimulus(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
                          3'($urandom_range(0, 7)), ra[0], ra[1], ra[2]);
        end

        applyStimulus(0, 0, 0, 3'b000, 0, 0, 0);
        @(posedge clk); #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
